// File: rtl/ren_pkt_queue_pkg.sv
// Shared types for the decode->rename instruction buffer: packet layout,
// queue geometry and the serialising-packet predicate.
package ren_pkt_queue_pkg;

  localparam int DEPTH     = 16;
  localparam int DEPTH_LOG = 4;
  localparam int IN_WIDTH  = 2;
  localparam int OUT_WIDTH = 2;

  typedef struct packed {
    logic        valid;
    logic [7:0]  seqNo;
    logic [31:0] pc;
    logic        isCSR;
    logic        isSret;
    logic        exception;
  } ren_pkt_t;

  typedef enum logic {
    NORMAL      = 1'b0,
    SERIAL_WAIT = 1'b1
  } q_state_e;

  // Packets that must reach rename alone, with the back end drained.
  function automatic logic is_serial(ren_pkt_t p);
    return p.isCSR | p.isSret | p.exception;
  endfunction

endpackage

// File: rtl/ren_pkt_queue_if.sv
// Decode-side push and rename-side pop signals of the packet queue.
interface ren_pkt_queue_if;
  import ren_pkt_queue_pkg::*;

  ren_pkt_t ibPacket0_i;
  ren_pkt_t ibPacket1_i;
  logic     stall_o;
  ren_pkt_t renPacket0_o;
  ren_pkt_t renPacket1_o;
  logic     renameStall_i;

  modport master (
    output ibPacket0_i, ibPacket1_i, renameStall_i,
    input  stall_o, renPacket0_o, renPacket1_o
  );

  modport slave (
    input  ibPacket0_i, ibPacket1_i, renameStall_i,
    output stall_o, renPacket0_o, renPacket1_o
  );
endinterface

// File: rtl/ren_pkt_queue_ctrl.sv
// Pointer, occupancy and serialisation control for ren_pkt_queue; decides
// how many packets are accepted and released each cycle.
module ren_pkt_queue_ctrl
  import ren_pkt_queue_pkg::*;
#(
  parameter int DEPTH     = ren_pkt_queue_pkg::DEPTH,
  parameter int DEPTH_LOG = ren_pkt_queue_pkg::DEPTH_LOG,
  parameter int IN_WIDTH  = ren_pkt_queue_pkg::IN_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 in0_v,
  input  logic                 in1_v,
  input  logic                 head0_ser,
  input  logic                 head1_ser,
  input  logic                 rename_stall,
  input  logic                 be_empty,
  output logic                 stall,
  output logic                 rel0,
  output logic                 rel1,
  output logic [DEPTH_LOG-1:0] head_idx,
  output logic [DEPTH_LOG-1:0] tail_idx,
  output logic [DEPTH_LOG:0]   occ
);

  localparam logic [DEPTH_LOG:0] STALL_TH = (DEPTH_LOG+1)'(DEPTH - IN_WIDTH);

  logic [DEPTH_LOG:0] head_q, head_d, tail_q, tail_d, occ_q, occ_d;
  q_state_e           state_q, state_d;
  logic [1:0]         push_cnt, pop_cnt;
  logic               empty, has2, can_rel;

  always_comb begin
    stall    = occ_q > STALL_TH;
    push_cnt = stall ? 2'd0 : 2'(in0_v) + 2'(in1_v);
    empty    = head_q == tail_q;
    has2     = occ_q > (DEPTH_LOG+1)'(1);
    can_rel  = !rename_stall && !flush_i && !empty;
    rel0     = 1'b0;
    rel1     = 1'b0;
    state_d  = state_q;
    case (state_q)
      NORMAL: begin
        if (!empty && head0_ser) begin
          // A serialising head goes alone, and only into a drained back end.
          if (be_empty) rel0 = can_rel;
          else          state_d = SERIAL_WAIT;
        end else begin
          rel0 = can_rel;
          rel1 = can_rel && has2 && !head1_ser;
        end
      end
      SERIAL_WAIT: begin
        if (can_rel && be_empty) begin
          rel0    = 1'b1;
          state_d = NORMAL;
        end
      end
    endcase
    pop_cnt = 2'(rel0) + 2'(rel1);
    head_d  = head_q + (DEPTH_LOG+1)'(pop_cnt);
    tail_d  = tail_q + (DEPTH_LOG+1)'(push_cnt);
    occ_d   = occ_q + (DEPTH_LOG+1)'(push_cnt) - (DEPTH_LOG+1)'(pop_cnt);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      occ_d   = '0;
      state_d = NORMAL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      state_q <= NORMAL;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      state_q <= state_d;
    end
  end

  assign head_idx = head_q[DEPTH_LOG-1:0];
  assign tail_idx = tail_q[DEPTH_LOG-1:0];
  assign occ      = occ_q;

endmodule

// File: rtl/ren_pkt_queue.sv
// Decode->rename packet queue: two-wide push, two-wide in-order release,
// CSR/exception serialisation and flush.
module ren_pkt_queue
  import ren_pkt_queue_pkg::*;
#(
  parameter int DEPTH     = ren_pkt_queue_pkg::DEPTH,
  parameter int DEPTH_LOG = ren_pkt_queue_pkg::DEPTH_LOG,
  parameter int IN_WIDTH  = ren_pkt_queue_pkg::IN_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_i,
  input  logic                backEndEmpty_i,
  output logic [DEPTH_LOG:0]  occupancy_o,
  ren_pkt_queue_if.slave      q_if
);

  localparam logic [DEPTH_LOG-1:0] IDX_ONE = DEPTH_LOG'(1);

  ren_pkt_t             mem_q [DEPTH];
  ren_pkt_t             mem_d [DEPTH];
  ren_pkt_t             head0, head1;
  logic [DEPTH_LOG-1:0] head_idx, tail_idx, head1_idx, wr1_idx;
  logic                 stall, rel0, rel1;

  assign head1_idx = head_idx + IDX_ONE;
  assign head0     = mem_q[head_idx];
  assign head1     = mem_q[head1_idx];
  // A lone packet 1 is compacted into the tail slot.
  assign wr1_idx   = q_if.ibPacket0_i.valid ? tail_idx + IDX_ONE : tail_idx;

  ren_pkt_queue_ctrl #(
    .DEPTH     (DEPTH),
    .DEPTH_LOG (DEPTH_LOG),
    .IN_WIDTH  (IN_WIDTH)
  ) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush_i),
    .in0_v        (q_if.ibPacket0_i.valid),
    .in1_v        (q_if.ibPacket1_i.valid),
    .head0_ser    (is_serial(head0)),
    .head1_ser    (is_serial(head1)),
    .rename_stall (q_if.renameStall_i),
    .be_empty     (backEndEmpty_i),
    .stall        (stall),
    .rel0         (rel0),
    .rel1         (rel1),
    .head_idx     (head_idx),
    .tail_idx     (tail_idx),
    .occ          (occupancy_o)
  );

  always_comb begin
    mem_d = mem_q;
    if (!flush_i && !stall) begin
      if (q_if.ibPacket0_i.valid) mem_d[tail_idx] = q_if.ibPacket0_i;
      if (q_if.ibPacket1_i.valid) mem_d[wr1_idx]  = q_if.ibPacket1_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  always_comb begin
    q_if.stall_o            = stall;
    q_if.renPacket0_o       = rel0 ? head0 : '0;
    q_if.renPacket0_o.valid = rel0;
    q_if.renPacket1_o       = rel1 ? head1 : '0;
    q_if.renPacket1_o.valid = rel1;
  end

endmodule
